rob_commit_unit: RTL and testbench
==================================

# rob_commit_unit

Parametrised reorder buffer and in-order commit stage that replaces the fixed-size writeback top. Decode allocates entries in program order. Any of `NUM_WB_PORTS` execution pipes (ALU, MUL, cache, …) complete entries out of order. The block retires the oldest completed entry each cycle into the register file, or raises a precise exception and flushes. Optional bypass lookup ports let issue logic read completed-but-uncommitted results.

## Interface
Parameters:
- `NUM_ENTRIES`, 8: ROB depth, power of two, ≥ 2; `ID_W = $clog2(NUM_ENTRIES)`.
- `NUM_WB_PORTS`, 3: number of completion ports.
- `NUM_BYP_PORTS`, 4: number of bypass lookup ports.
- `DATA_W`, 32: result width.
- `REG_W`, 5: destination register address width.
- `PC_W`, 32: PC width.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `alloc_valid` in 1: decode requests an entry.
- `alloc_ready` out 1: entry is available this cycle.
- `alloc_id` out ID_W: ID granted; equals the tail pointer.
- `alloc_dest` in REG_W: destination register.
- `alloc_wr` in 1: instruction writes the RF.
- `alloc_pc` in PC_W: instruction PC.
- `wb_valid` in NUM_WB_PORTS: per-port completion strobe.
- `wb_id` in NUM_WB_PORTS*ID_W: ROB ID of each completion.
- `wb_data` in NUM_WB_PORTS*DATA_W: result of each completion.
- `wb_xcpt` in NUM_WB_PORTS: completion carries an exception.
- `rf_wr_en` out 1: RF write strobe.
- `rf_wr_data` out DATA_W: RF write data.
- `rf_wr_dest` out REG_W: RF write address.
- `rf_wr_id` out ID_W: ROB ID of the committed entry.
- `xcpt_valid` out 1: one-cycle exception pulse.
- `xcpt_pc` out PC_W: PC of the excepting instruction.
- `xcpt_id` out ID_W: ROB ID of the excepting instruction.
- `rob_full` out 1: all entries valid.
- `rob_empty` out 1: no entries valid.
- `rob_oldest` out ID_W: head pointer.
- `rob_count` out ID_W+1: number of valid entries.
- `byp_id` in NUM_BYP_PORTS*ID_W: bypass lookup IDs.
- `byp_hit` out NUM_BYP_PORTS: lookup found a completed result.
- `byp_data` out NUM_BYP_PORTS*DATA_W: bypassed result.

## Operation
- Each entry holds `valid`, `done`, `xcpt`, `wr`, `dest`, `pc` and `data`. The block keeps head and tail pointers of ID_W bits that wrap modulo NUM_ENTRIES, plus `count`.
- **Allocation.** `alloc_ready = !rob_full && !flush`. When `alloc_valid && alloc_ready`, the tail entry is written with `valid=1`, `done=0`, `xcpt=0`, and tail increments.
- **Completion.** For each port p with `wb_valid[p]`:
  - If the target entry is valid, set `done=1`, store the data and set `xcpt=wb_xcpt[p]`.
  - A completion to an invalid entry is ignored.
  - If two ports hit the same ID in one cycle, the lowest port index wins.
- **Commit.** Evaluated each cycle on the head entry. When it is `valid && done`:
  - Without exception: the entry is freed and head increments. Next cycle, `rf_wr_en` = the entry's `wr`, and `rf_wr_data`, `rf_wr_dest` and `rf_wr_id` carry the entry's values.
  - With exception (`flush`): next cycle `xcpt_valid=1` with `xcpt_pc` and `xcpt_id`, and `rf_wr_en=0`. At the same edge every entry is invalidated, head=tail=0 and count=0. Allocation is blocked during the flush cycle. Completions in the flush cycle are discarded.
- **Count update.** count changes by +alloc −retire. Simultaneous alloc and retire leave count unchanged. `rob_full` is taken from the registered count, so a full ROB refuses allocation even in a cycle where it retires.
- At most one commit per cycle.

## Timing
- Reset values: all entries invalid, head=tail=count=0, `rob_empty=1`. `rf_wr_en`, `xcpt_valid`, `rob_full` and `byp_hit` are all 0. All data, PC, ID and dest outputs are 0.
- Minimum latency:
  - Allocation in cycle 0.
  - Completion in cycle 1.
  - `done` visible in cycle 2.
  - `rf_wr_en` high in cycle 3.
- `alloc_id` and `alloc_ready` are combinational from registered state and the head-commit decision.
- `rf_*` and `xcpt_*` outputs are registered and pulse for exactly one cycle per event.
- Reset asserted mid-operation clears everything immediately, including any pending output pulse.

## Configuration
- `ROB_BYPASS_EN` defined:
  - For each lookup port, `byp_hit=1` when the entry is valid and `done`, or when a same-cycle completion targets that ID.
  - On a same-cycle completion, the `wb_data` of the lowest-indexed matching port is forwarded in preference to the stored data.
  - Combinational path.
- `ROB_BYPASS_EN` undefined:
  - `byp_hit` and `byp_data` are tied to 0.
  - No lookup muxes are built; `byp_id` is unused.

## Test plan
- Reset, then allocate IDs 0, 1, 2 (dest 3, 4, 5). Complete them in order 2, 0, 1 with data 0xA, 0xB, 0xC. -> RF writes occur in order: dest 3=0xB, dest 4=0xC, dest 5=0xA, on three consecutive cycles.
- Allocate 8 entries with NUM_ENTRIES=8 -> `rob_full=1`, `alloc_ready=0`, `rob_count=8`. Retire one and allocate -> the new ID is 0 (wrap) and count stays 8.
- Allocate IDs 0–3 and complete them all, ID 1 with `wb_xcpt=1`, `alloc_pc` of ID 1 = 0x40. -> ID 0 commits. Next, `xcpt_valid=1`, `xcpt_pc=0x40`, `xcpt_id=1`, and no RF write for IDs 1–3. Then `rob_empty=1` and the next allocation gets ID 0.
- In one cycle, port 0 and port 2 both complete ID 4, with 0x11 and 0x22. -> The committed data is 0x11.
- With `ROB_BYPASS_EN`: `byp_id`=5 while port 1 completes ID 5 with 0x77 in the same cycle. -> `byp_hit=1` and `byp_data=0x77` that cycle. Without the macro, `byp_hit` stays 0.
- Assert `reset` low while 3 entries are pending and an RF write is due next cycle. -> No RF write occurs, `rob_count=0`, and all outputs are at their reset values.

Source files
------------

// File: rtl/rob_commit_unit.sv
// Reorder buffer: in-order allocation, out-of-order completion, in-order commit with precise flush.
// Define ROB_BYPASS_EN to build the combinational bypass lookup ports.
module rob_commit_unit #(
  parameter int NUM_ENTRIES   = 8,
  parameter int NUM_WB_PORTS  = 3,
  parameter int NUM_BYP_PORTS = 4,
  parameter int DATA_W        = 32,
  parameter int REG_W         = 5,
  parameter int PC_W          = 32,
  parameter int ID_W          = $clog2(NUM_ENTRIES)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              alloc_valid,
  output logic                              alloc_ready,
  output logic [ID_W-1:0]                   alloc_id,
  input  logic [REG_W-1:0]                  alloc_dest,
  input  logic                              alloc_wr,
  input  logic [PC_W-1:0]                   alloc_pc,
  input  logic [NUM_WB_PORTS-1:0]           wb_valid,
  input  logic [NUM_WB_PORTS*ID_W-1:0]      wb_id,
  input  logic [NUM_WB_PORTS*DATA_W-1:0]    wb_data,
  input  logic [NUM_WB_PORTS-1:0]           wb_xcpt,
  output logic                              rf_wr_en,
  output logic [DATA_W-1:0]                 rf_wr_data,
  output logic [REG_W-1:0]                  rf_wr_dest,
  output logic [ID_W-1:0]                   rf_wr_id,
  output logic                              xcpt_valid,
  output logic [PC_W-1:0]                   xcpt_pc,
  output logic [ID_W-1:0]                   xcpt_id,
  output logic                              rob_full,
  output logic                              rob_empty,
  output logic [ID_W-1:0]                   rob_oldest,
  output logic [ID_W:0]                     rob_count,
  input  logic [NUM_BYP_PORTS*ID_W-1:0]     byp_id,
  output logic [NUM_BYP_PORTS-1:0]          byp_hit,
  output logic [NUM_BYP_PORTS*DATA_W-1:0]   byp_data
);

  logic [NUM_ENTRIES-1:0] valid_q, done_q, xcpt_q, wr_q;
  logic [REG_W-1:0]       dest_q [NUM_ENTRIES];
  logic [PC_W-1:0]        pc_q   [NUM_ENTRIES];
  logic [DATA_W-1:0]      data_q [NUM_ENTRIES];

  logic [ID_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ID_W:0]   count_q, count_d;

  logic              rf_wr_en_q, xcpt_valid_q;
  logic [DATA_W-1:0] rf_wr_data_q;
  logic [REG_W-1:0]  rf_wr_dest_q;
  logic [ID_W-1:0]   rf_wr_id_q, xcpt_id_q;
  logic [PC_W-1:0]   xcpt_pc_q;

  logic headReady, flush, retire, allocFire;
  logic [ID_W-1:0] wbIdx [NUM_WB_PORTS];

  for (genvar p = 0; p < NUM_WB_PORTS; p++) begin : gWbIdx
    assign wbIdx[p] = wb_id[p*ID_W +: ID_W];
  end

  assign headReady   = valid_q[head_q] && done_q[head_q];
  assign flush       = headReady && xcpt_q[head_q];
  assign retire      = headReady && !xcpt_q[head_q];
  assign rob_full    = (count_q == (ID_W+1)'(NUM_ENTRIES));
  assign rob_empty   = (count_q == '0);
  assign alloc_ready = !rob_full && !flush;
  assign allocFire   = alloc_valid && alloc_ready;
  assign alloc_id    = tail_q;
  assign rob_oldest  = head_q;
  assign rob_count   = count_q;

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_data = rf_wr_data_q;
  assign rf_wr_dest = rf_wr_dest_q;
  assign rf_wr_id   = rf_wr_id_q;
  assign xcpt_valid = xcpt_valid_q;
  assign xcpt_pc    = xcpt_pc_q;
  assign xcpt_id    = xcpt_id_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (retire)    head_d = head_q + 1'b1;
      if (allocFire) tail_d = tail_q + 1'b1;
      count_d = count_q + (ID_W+1)'(allocFire) - (ID_W+1)'(retire);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Ports are scanned high to low so the lowest-indexed port's write lands last and wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      done_q  <= '0;
      xcpt_q  <= '0;
      wr_q    <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        dest_q[i] <= '0;
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
      done_q  <= '0;
      xcpt_q  <= '0;
    end else begin
      if (allocFire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        xcpt_q[tail_q]  <= 1'b0;
        wr_q[tail_q]    <= alloc_wr;
        dest_q[tail_q]  <= alloc_dest;
        pc_q[tail_q]    <= alloc_pc;
      end
      for (int p = NUM_WB_PORTS-1; p >= 0; p--) begin
        if (wb_valid[p] && valid_q[wbIdx[p]]) begin
          done_q[wbIdx[p]] <= 1'b1;
          xcpt_q[wbIdx[p]] <= wb_xcpt[p];
          data_q[wbIdx[p]] <= wb_data[p*DATA_W +: DATA_W];
        end
      end
      if (retire) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_data_q <= '0;
      rf_wr_dest_q <= '0;
      rf_wr_id_q   <= '0;
      xcpt_valid_q <= 1'b0;
      xcpt_pc_q    <= '0;
      xcpt_id_q    <= '0;
    end else begin
      rf_wr_en_q   <= retire && wr_q[head_q];
      xcpt_valid_q <= flush;
      if (retire) begin
        rf_wr_data_q <= data_q[head_q];
        rf_wr_dest_q <= dest_q[head_q];
        rf_wr_id_q   <= head_q;
      end
      if (flush) begin
        xcpt_pc_q <= pc_q[head_q];
        xcpt_id_q <= head_q;
      end
    end
  end

`ifdef ROB_BYPASS_EN
  logic [ID_W-1:0] bypIdx;

  // A same-cycle completion overrides the stored result; lowest matching port wins.
  always_comb begin
    byp_hit  = '0;
    byp_data = '0;
    bypIdx   = '0;
    for (int b = 0; b < NUM_BYP_PORTS; b++) begin
      bypIdx     = byp_id[b*ID_W +: ID_W];
      byp_hit[b] = valid_q[bypIdx] && done_q[bypIdx];
      byp_data[b*DATA_W +: DATA_W] = data_q[bypIdx];
      for (int p = NUM_WB_PORTS-1; p >= 0; p--) begin
        if (wb_valid[p] && valid_q[bypIdx] && (wbIdx[p] == bypIdx)) begin
          byp_hit[b] = 1'b1;
          byp_data[b*DATA_W +: DATA_W] = wb_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end
`else
  logic unusedBypId;
  assign unusedBypId = ^byp_id;
  assign byp_hit     = '0;
  assign byp_data    = '0;
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
// Testbench for rob_commit_unit: directed scenarios plus random traffic against a queue-based model.
// Expectations follow ROB_BYPASS_EN the same way the design does.
module tb_rob_commit_unit;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         alloc_valid;
  logic         alloc_ready;
  logic [2:0]   alloc_id;
  logic [4:0]   alloc_dest;
  logic         alloc_wr;
  logic [31:0]  alloc_pc;
  logic [2:0]   wb_valid;
  logic [8:0]   wb_id;
  logic [95:0]  wb_data;
  logic [2:0]   wb_xcpt;
  logic         rf_wr_en;
  logic [31:0]  rf_wr_data;
  logic [4:0]   rf_wr_dest;
  logic [2:0]   rf_wr_id;
  logic         xcpt_valid;
  logic [31:0]  xcpt_pc;
  logic [2:0]   xcpt_id;
  logic         rob_full;
  logic         rob_empty;
  logic [2:0]   rob_oldest;
  logic [3:0]   rob_count;
  logic [11:0]  byp_id;
  logic [3:0]   byp_hit;
  logic [127:0] byp_data;

  rob_commit_unit dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .alloc_dest(alloc_dest), .alloc_wr(alloc_wr), .alloc_pc(alloc_pc),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .wb_xcpt(wb_xcpt),
    .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data), .rf_wr_dest(rf_wr_dest), .rf_wr_id(rf_wr_id),
    .xcpt_valid(xcpt_valid), .xcpt_pc(xcpt_pc), .xcpt_id(xcpt_id),
    .rob_full(rob_full), .rob_empty(rob_empty), .rob_oldest(rob_oldest), .rob_count(rob_count),
    .byp_id(byp_id), .byp_hit(byp_hit), .byp_data(byp_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [4:0]  dest;
    logic        wr;
    logic [31:0] pc;
    logic        done;
    logic        xcpt;
    logic [31:0] data;
  } entry_t;

  typedef struct {
    int          cyc;
    int          id;
    logic [4:0]  dest;
    logic [31:0] data;
  } rfRec_t;

  typedef struct {
    int          id;
    logic [31:0] pc;
  } xcRec_t;

  entry_t robQ[$];
  rfRec_t rfLog[$];
  xcRec_t xcptLog[$];
  int nextId = 0;
  int cycleNo = 0;
  int lastAllocIdObs = -1;
  logic [3:0]   lastBypHit;
  logic [127:0] lastBypData;
  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    alloc_dest  = '0;
    alloc_wr    = 1'b0;
    alloc_pc    = '0;
    wb_valid    = '0;
    wb_id       = '0;
    wb_data     = '0;
    wb_xcpt     = '0;
    byp_id      = '0;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_rf_wr_en",   64'(rf_wr_en),   64'(0));
    checkOutput("rst_rf_wr_data", 64'(rf_wr_data), 64'(0));
    checkOutput("rst_rf_wr_dest", 64'(rf_wr_dest), 64'(0));
    checkOutput("rst_rf_wr_id",   64'(rf_wr_id),   64'(0));
    checkOutput("rst_xcpt_valid", 64'(xcpt_valid), 64'(0));
    checkOutput("rst_xcpt_pc",    64'(xcpt_pc),    64'(0));
    checkOutput("rst_xcpt_id",    64'(xcpt_id),    64'(0));
    checkOutput("rst_rob_full",   64'(rob_full),   64'(0));
    checkOutput("rst_rob_empty",  64'(rob_empty),  64'(1));
    checkOutput("rst_rob_oldest", 64'(rob_oldest), 64'(0));
    checkOutput("rst_rob_count",  64'(rob_count),  64'(0));
    checkOutput("rst_alloc_id",   64'(alloc_id),   64'(0));
    checkOutput("rst_byp_hit",    64'(byp_hit),    64'(0));
    checkOutput("rst_byp_data0",  byp_data[63:0],  64'(0));
  endtask

  // Asserts reset asynchronously mid-cycle, so any output pulse due at the next edge must vanish.
  task automatic doReset();
    idle();
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    checkResetValues();
    reset = 1'b1;
    robQ.delete();
    nextId = 0;
  endtask

  // One clock cycle: check combinational outputs, advance the model, then check registered outputs.
  task automatic applyStimulus();
    entry_t      head;
    entry_t      e;
    logic        headReady, flush, retire, allocOk;
    logic        expRfEn, expXcpt;
    logic [31:0] expRfData, expXcptPc;
    logic [4:0]  expRfDest;
    int          expRfId, expXcptId;
    int          sizeNow, oldest, wid;
    logic [7:0]  claimed;
    #1;
    sizeNow   = robQ.size();
    headReady = (sizeNow > 0) && robQ[0].done;
    flush     = headReady && robQ[0].xcpt;
    retire    = headReady && !robQ[0].xcpt;
    oldest    = (sizeNow > 0) ? robQ[0].id : nextId;
    allocOk   = alloc_valid && (sizeNow < 8) && !flush;
    if (sizeNow > 0) head = robQ[0];
    checkOutput("alloc_ready", 64'(alloc_ready), 64'((sizeNow < 8) && !flush));
    checkOutput("alloc_id",    64'(alloc_id),    64'(nextId));
    checkOutput("rob_count",   64'(rob_count),   64'(sizeNow));
    checkOutput("rob_full",    64'(rob_full),    64'(sizeNow == 8));
    checkOutput("rob_empty",   64'(rob_empty),   64'(sizeNow == 0));
    checkOutput("rob_oldest",  64'(rob_oldest),  64'(oldest));
    lastBypHit  = byp_hit;
    lastBypData = byp_data;
    if (alloc_valid && alloc_ready) lastAllocIdObs = int'(alloc_id);
`ifdef ROB_BYPASS_EN
    for (int b = 0; b < 4; b++) begin
      int          bid;
      logic        expHit, found, taken;
      logic [31:0] expData;
      bid = int'(byp_id[b*3 +: 3]);
      expHit = 1'b0; expData = '0; found = 1'b0; taken = 1'b0;
      foreach (robQ[k]) if (robQ[k].id == bid) begin
        found = 1'b1; expHit = robQ[k].done; expData = robQ[k].data;
      end
      for (int p = 0; p < 3; p++) begin
        if (found && !taken && wb_valid[p] && int'(wb_id[p*3 +: 3]) == bid) begin
          taken = 1'b1; expHit = 1'b1; expData = wb_data[p*32 +: 32];
        end
      end
      checkOutput($sformatf("byp_hit%0d", b), 64'(byp_hit[b]), 64'(expHit));
      if (expHit) checkOutput($sformatf("byp_data%0d", b), 64'(byp_data[b*32 +: 32]), 64'(expData));
    end
`else
    checkOutput("byp_hit_off", 64'(byp_hit), 64'(0));
    checkOutput("byp_data_off", byp_data[63:0], 64'(0));
`endif
    if (!flush) begin
      claimed = '0;
      for (int p = 0; p < 3; p++) begin
        if (wb_valid[p]) begin
          wid = int'(wb_id[p*3 +: 3]);
          if (!claimed[wid]) begin
            claimed[wid] = 1'b1;
            foreach (robQ[k]) if (robQ[k].id == wid) begin
              robQ[k].done = 1'b1;
              robQ[k].xcpt = wb_xcpt[p];
              robQ[k].data = wb_data[p*32 +: 32];
            end
          end
        end
      end
    end
    expRfEn = retire && head.wr;
    expXcpt = flush;
    expRfData = '0; expRfDest = '0; expRfId = 0; expXcptPc = '0; expXcptId = 0;
    if (retire) begin
      expRfData = head.data; expRfDest = head.dest; expRfId = head.id;
      void'(robQ.pop_front());
    end
    if (flush) begin
      expXcptPc = head.pc; expXcptId = head.id;
      robQ.delete();
      nextId = 0;
    end
    if (allocOk) begin
      e.id = nextId; e.dest = alloc_dest; e.wr = alloc_wr; e.pc = alloc_pc;
      e.done = 1'b0; e.xcpt = 1'b0; e.data = '0;
      robQ.push_back(e);
      nextId = (nextId + 1) % 8;
    end
    @(posedge clock);
    #1;
    cycleNo++;
    checkOutput("rf_wr_en", 64'(rf_wr_en), 64'(expRfEn));
    if (expRfEn) begin
      checkOutput("rf_wr_data", 64'(rf_wr_data), 64'(expRfData));
      checkOutput("rf_wr_dest", 64'(rf_wr_dest), 64'(expRfDest));
      checkOutput("rf_wr_id",   64'(rf_wr_id),   64'(expRfId));
    end
    checkOutput("xcpt_valid", 64'(xcpt_valid), 64'(expXcpt));
    if (expXcpt) begin
      checkOutput("xcpt_pc", 64'(xcpt_pc), 64'(expXcptPc));
      checkOutput("xcpt_id", 64'(xcpt_id), 64'(expXcptId));
    end
    if (rf_wr_en) rfLog.push_back('{cyc: cycleNo, id: int'(rf_wr_id), dest: rf_wr_dest, data: rf_wr_data});
    if (xcpt_valid) xcptLog.push_back('{id: int'(xcpt_id), pc: xcpt_pc});
  endtask

  task automatic allocOne(input logic [4:0] dest, input logic wr, input logic [31:0] pc);
    idle();
    alloc_valid = 1'b1; alloc_dest = dest; alloc_wr = wr; alloc_pc = pc;
    applyStimulus();
  endtask

  task automatic completeOne(input int id, input logic [31:0] data, input logic xc);
    idle();
    wb_valid[0] = 1'b1; wb_id[2:0] = 3'(id); wb_data[31:0] = data; wb_xcpt[0] = xc;
    applyStimulus();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      applyStimulus();
    end
  endtask

  initial begin
    logic [31:0] foundData;
    int          sz, pick;
    idle();
    $display("[TB] reset values");
    doReset();

    $display("[TB] out-of-order completion, in-order commit");
    rfLog.delete();
    for (int i = 0; i < 3; i++) allocOne(5'(3 + i), 1'b1, 32'(16 * i));
    completeOne(2, 32'hA, 1'b0);
    completeOne(0, 32'hB, 1'b0);
    completeOne(1, 32'hC, 1'b0);
    idleCycles(5);
    checkOutput("ooo_writes", 64'(rfLog.size()), 64'(3));
    checkOutput("ooo_dest0", 64'(rfLog[0].dest), 64'(3));
    checkOutput("ooo_data0", 64'(rfLog[0].data), 64'hB);
    checkOutput("ooo_dest1", 64'(rfLog[1].dest), 64'(4));
    checkOutput("ooo_data1", 64'(rfLog[1].data), 64'hC);
    checkOutput("ooo_dest2", 64'(rfLog[2].dest), 64'(5));
    checkOutput("ooo_data2", 64'(rfLog[2].data), 64'hA);
    checkOutput("ooo_back2back", 64'(rfLog[2].cyc - rfLog[0].cyc), 64'(2));

    $display("[TB] full ROB and pointer wrap");
    doReset();
    for (int i = 0; i < 8; i++) allocOne(5'(i), 1'b1, 32'(4 * i));
    checkOutput("full_flag",  64'(rob_full),    64'(1));
    checkOutput("full_ready", 64'(alloc_ready), 64'(0));
    checkOutput("full_count", 64'(rob_count),   64'(8));
    lastAllocIdObs = -1;
    idle(); alloc_valid = 1'b1; alloc_dest = 5'd9; alloc_wr = 1'b1;
    wb_valid[0] = 1'b1; wb_id[2:0] = 3'd0; wb_data[31:0] = 32'h55;
    applyStimulus();
    wb_valid = '0;
    applyStimulus();
    checkOutput("full_retire_refused", 64'(lastAllocIdObs), 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus();
    checkOutput("wrap_id", 64'(lastAllocIdObs), 64'(0));
    checkOutput("wrap_count", 64'(rob_count), 64'(8));

    $display("[TB] precise exception and flush");
    doReset();
    rfLog.delete(); xcptLog.delete();
    for (int i = 0; i < 4; i++) allocOne(5'(10 + i), 1'b1, 32'h3C + 32'(4 * i));
    idle();
    wb_valid = 3'b111; wb_id = {3'd2, 3'd1, 3'd0};
    wb_data = {32'h102, 32'h101, 32'h100}; wb_xcpt = 3'b010;
    applyStimulus();
    completeOne(3, 32'h103, 1'b0);
    idleCycles(4);
    checkOutput("xc_rf_writes", 64'(rfLog.size()), 64'(1));
    checkOutput("xc_rf_id", 64'(rfLog[0].id), 64'(0));
    checkOutput("xc_pulses", 64'(xcptLog.size()), 64'(1));
    checkOutput("xc_pc", 64'(xcptLog[0].pc), 64'h40);
    checkOutput("xc_id", 64'(xcptLog[0].id), 64'(1));
    checkOutput("xc_empty", 64'(rob_empty), 64'(1));
    lastAllocIdObs = -1;
    allocOne(5'd1, 1'b1, 32'h80);
    checkOutput("xc_next_id", 64'(lastAllocIdObs), 64'(0));

    $display("[TB] same-ID completion on two ports");
    doReset();
    rfLog.delete();
    for (int i = 0; i < 5; i++) allocOne(5'(1 + i), 1'b1, 32'(8 * i));
    idle();
    wb_valid = 3'b111; wb_id = {3'd2, 3'd1, 3'd0}; wb_data = {32'h3, 32'h2, 32'h1};
    applyStimulus();
    idle();
    wb_valid = 3'b111; wb_id = {3'd4, 3'd3, 3'd4}; wb_data = {32'h22, 32'h4, 32'h11};
    applyStimulus();
    idleCycles(8);
    foundData = '1;
    foreach (rfLog[k]) if (rfLog[k].id == 4) foundData = rfLog[k].data;
    checkOutput("dup_writes", 64'(rfLog.size()), 64'(5));
    checkOutput("dup_data", 64'(foundData), 64'h11);

    $display("[TB] bypass lookup");
    doReset();
    for (int i = 0; i < 6; i++) allocOne(5'(i), 1'b1, 32'(i));
    idle();
    byp_id[2:0] = 3'd5;
    wb_valid[1] = 1'b1; wb_id[5:3] = 3'd5; wb_data[63:32] = 32'h77;
    applyStimulus();
`ifdef ROB_BYPASS_EN
    checkOutput("byp_same_cycle_hit",  64'(lastBypHit[0]), 64'(1));
    checkOutput("byp_same_cycle_data", 64'(lastBypData[31:0]), 64'h77);
`else
    checkOutput("byp_disabled_hit", 64'(lastBypHit), 64'(0));
`endif

    $display("[TB] reset with a pending RF write");
    doReset();
    for (int i = 0; i < 3; i++) allocOne(5'(20 + i), 1'b1, 32'(i));
    completeOne(0, 32'hDEAD, 1'b0);
    doReset();

    $display("[TB] random traffic");
    doReset();
    for (int c = 0; c < 400; c++) begin
      idle();
      alloc_valid = ($urandom_range(0, 99) < 65);
      alloc_dest  = 5'($urandom);
      alloc_wr    = ($urandom_range(0, 9) < 8);
      alloc_pc    = $urandom;
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 99) < 40) begin
          sz = robQ.size();
          if (sz > 0 && $urandom_range(0, 3) != 0) begin
            pick = int'($urandom_range(0, sz - 1));
            wb_id[p*3 +: 3] = 3'(robQ[pick].id);
          end else begin
            wb_id[p*3 +: 3] = 3'($urandom_range(0, 7));
          end
          wb_valid[p] = 1'b1;
          wb_data[p*32 +: 32] = $urandom;
          wb_xcpt[p] = ($urandom_range(0, 99) < 3);
        end
      end
      byp_id = 12'($urandom);
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
